mem_bank_ram: RTL

//  - Four-bank, simple dual-port RAM (one write port, one read port) that consumes the
//    one-hot bank selects produced by the 2-to-4 memory address decoder.
//  - Each port gets a one-hot bank select plus an in-bank offset address.
//  - Registered read path with 1-cycle latency and a valid strobe.
//  - Illegal (non-one-hot) selects are rejected and flagged.

---
 rtl/mem_bank_ram.sv | 94 +++++++++
 1 files changed

// File: rtl/mem_bank_ram.sv
// Four-bank simple dual-port RAM addressed by one-hot bank selects, 1-cycle registered read.
// Define READ_BYPASS_EN to forward write data on a same-location read/write collision.
module mem_bank_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_BANKS  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [NUM_BANKS-1:0]  wr_bank_sel_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [NUM_BANKS-1:0]  rd_bank_sel_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  sel_err_o
);

    localparam int unsigned BankDepth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS][BankDepth];

    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  sel_err_q, sel_err_d;

    logic                  wr_legal, rd_legal;
    logic                  wr_ok, rd_ok;
    logic [1:0]            wr_bank, rd_bank;

    // Only meaningful for a legal (one-hot) select.
    function automatic logic [1:0] sel_to_bank(input logic [NUM_BANKS-1:0] sel);
        logic [1:0] bank;
        bank = 2'd0;
        case (sel)
            4'b0001: bank = 2'd0;
            4'b0010: bank = 2'd1;
            4'b0100: bank = 2'd2;
            4'b1000: bank = 2'd3;
            default: bank = 2'd0;
        endcase
        return bank;
    endfunction

    always_comb begin
        wr_legal = $onehot(wr_bank_sel_i);
        rd_legal = $onehot(rd_bank_sel_i);
        wr_ok    = wr_en_i && wr_legal;
        rd_ok    = rd_en_i && rd_legal;
        wr_bank  = sel_to_bank(wr_bank_sel_i);
        rd_bank  = sel_to_bank(rd_bank_sel_i);
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_ok;
        sel_err_d  = (wr_en_i && !wr_legal) || (rd_en_i && !rd_legal);
        if (rd_ok) begin
            rd_data_d = mem_q[rd_bank][rd_addr_i];
`ifdef READ_BYPASS_EN
            if (wr_ok && (wr_bank == rd_bank) && (wr_addr_i == rd_addr_i)) begin
                rd_data_d = wr_data_i;
            end
`endif
        end
    end

    // Array is deliberately not cleared by reset; requests in a reset cycle are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_ni && wr_ok) begin
            mem_q[wr_bank][wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign sel_err_o  = sel_err_q;

endmodule
